// File: rtl/vga_pkg.sv
// Shared colour-path definitions: fade FSM state encoding, default brightness scale
// and the MSB-first bit-replication helper used by colour expanders.
package vga_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    FADE_IN  = 2'd1,
    ON       = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

  localparam int BR_W_DEFAULT = 4;
  localparam int BR_MAX       = 2 ** BR_W_DEFAULT;

  // Output bit (out_w-1-i) takes input bit (in_w-1 - i mod in_w), so full scale maps to full scale.
  function automatic logic [31:0] replicate(input logic [31:0] d, input int in_w, input int out_w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < out_w) begin
        r[out_w-1-i] = d[in_w-1-(i % in_w)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_chan_scale.sv
// One colour channel: bit-replicate, register (S1), apply brightness gain and blanking,
// register again (S2). Two-clock latency, one pixel per clock.
module vga_chan_scale
  import vga_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int BR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [IN_W-1:0]   d,
  input  logic [BR_W:0]     brightness,
  output logic [OUT_W-1:0]  q
);

  localparam int PW = OUT_W + BR_W + 1;

  logic [31:0]      rep_s;
  logic [OUT_W-1:0] s1_r;
  logic             en1_r;
  logic [PW-1:0]    prod_s;
  logic [PW-1:0]    shifted_s;
  logic [OUT_W-1:0] q_r;
  logic             unused_bits_s;

  assign rep_s         = replicate(32'(d), IN_W, OUT_W);
  assign prod_s        = PW'(s1_r) * PW'(brightness);
  assign shifted_s     = prod_s >> BR_W;
  assign unused_bits_s = ^{rep_s, shifted_s};
  assign q             = q_r;

  // S1 captures the expanded pixel, S2 the gained/blanked result using the live brightness.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r  <= {OUT_W{1'b0}};
      en1_r <= 1'b0;
      q_r   <= {OUT_W{1'b0}};
    end else begin
      s1_r  <= rep_s[OUT_W-1:0];
      en1_r <= en;
      q_r   <= en1_r ? shifted_s[OUT_W-1:0] : {OUT_W{1'b0}};
    end
  end

endmodule

// File: rtl/vga_rgb_scaler.sv
// VGA RGB expander with global brightness, blanking and a frame-synchronous fade engine.
// Three channel slices share the brightness register owned by the fade FSM here.
module vga_rgb_scaler
  import vga_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int BR_W  = 4,
  parameter int STEP  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [IN_W-1:0]   r_d,
  input  logic [IN_W-1:0]   g_d,
  input  logic [IN_W-1:0]   b_d,
  input  logic              frame_tick,
  input  logic              fade_in,
  input  logic              fade_out,
  output logic [OUT_W-1:0]  r_q,
  output logic [OUT_W-1:0]  g_q,
  output logic [OUT_W-1:0]  b_q,
  output logic              en_q,
  output logic [BR_W:0]     brightness,
  output logic              fade_busy
);

  if (OUT_W < IN_W) begin : g_bad_width
    $error("vga_rgb_scaler: OUT_W must be >= IN_W");
  end
  if (STEP < 1) begin : g_bad_step
    $error("vga_rgb_scaler: STEP must be >= 1");
  end

  localparam int              BR_FULL_I = 2 ** BR_W;
  localparam logic [BR_W:0]   BR_FULL   = BR_FULL_I[BR_W:0];
  localparam logic [BR_W+1:0] STEP_W    = STEP[BR_W+1:0];

  fade_state_t     state_r, state_s;
  logic [BR_W:0]   brightness_r, bright_s;
  logic [BR_W+1:0] up_sum_s;
  logic            fade_busy_r;
  logic            en1_r, en_q_r;

  assign up_sum_s   = {1'b0, brightness_r} + STEP_W;
  assign brightness = brightness_r;
  assign fade_busy  = fade_busy_r;
  assign en_q       = en_q_r;

  // Fade next-state: a request pre-empts that cycle's step; fade_out dominates fade_in.
  always_comb begin
    state_s  = state_r;
    bright_s = brightness_r;
    case (state_r)
      OFF: begin
        if (fade_in && !fade_out) state_s = FADE_IN;
        else                      state_s = OFF;
      end
      ON: begin
        if (fade_out) state_s = FADE_OUT;
        else          state_s = ON;
      end
      FADE_IN: begin
        if (fade_out) begin
          state_s = FADE_OUT;
        end else if (frame_tick) begin
          if (up_sum_s >= {1'b0, BR_FULL}) begin
            bright_s = BR_FULL;
            state_s  = ON;
          end else begin
            bright_s = up_sum_s[BR_W:0];
            state_s  = FADE_IN;
          end
        end else begin
          state_s = FADE_IN;
        end
      end
      FADE_OUT: begin
        if (fade_in && !fade_out) begin
          state_s = FADE_IN;
        end else if (frame_tick) begin
          if ({1'b0, brightness_r} <= STEP_W) begin
            bright_s = {(BR_W+1){1'b0}};
            state_s  = OFF;
          end else begin
            bright_s = brightness_r - STEP_W[BR_W:0];
            state_s  = FADE_OUT;
          end
        end else begin
          state_s = FADE_OUT;
        end
      end
      default: begin
        state_s  = ON;
        bright_s = BR_FULL;
      end
    endcase
  end

  // Fade state, brightness, busy flag and the en alignment pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ON;
      brightness_r <= BR_FULL;
      fade_busy_r  <= 1'b0;
      en1_r        <= 1'b0;
      en_q_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      brightness_r <= bright_s;
      fade_busy_r  <= (state_s == FADE_IN) || (state_s == FADE_OUT);
      en1_r        <= en;
      en_q_r       <= en1_r;
    end
  end

  vga_chan_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_W(BR_W)) u_r (
    .clk(clk), .reset(reset), .en(en), .d(r_d), .brightness(brightness_r), .q(r_q)
  );
  vga_chan_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_W(BR_W)) u_g (
    .clk(clk), .reset(reset), .en(en), .d(g_d), .brightness(brightness_r), .q(g_q)
  );
  vga_chan_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_W(BR_W)) u_b (
    .clk(clk), .reset(reset), .en(en), .d(b_d), .brightness(brightness_r), .q(b_q)
  );

endmodule

// File: tb/tb_vga_rgb_scaler.sv
// Self-checking bench: two scalers (STEP=1 and STEP=5) on shared stimulus, compared
// every clock against a behavioural model of pixel gain and fade direction.
module tb_vga_rgb_scaler;

  localparam int FULL = 16;

  logic       clk = 1'b0;
  logic       reset, en, frame_tick, fade_in, fade_out;
  logic [1:0] r_d, g_d, b_d;
  logic [3:0] rq [2];
  logic [3:0] gq [2];
  logic [3:0] bq [2];
  logic       enq [2];
  logic [4:0] bri [2];
  logic       busy [2];

  int checks   = 0;
  int failures = 0;

  // Model state: pipeline stage 1, expected outputs, brightness and fade direction.
  int m_s1_en, m_s1_r, m_s1_g, m_s1_b;
  int m_en_q;
  int m_q [2][3];
  int m_b [2];
  int m_dir [2];
  int step_of [2] = '{1, 5};
  bit rnd_pix = 1'b0;
  bit rnd_en  = 1'b0;

  always #5 clk = ~clk;

  vga_rgb_scaler #(.IN_W(2), .OUT_W(4), .BR_W(4), .STEP(1)) dut (
    .clk(clk), .reset(reset), .en(en), .r_d(r_d), .g_d(g_d), .b_d(b_d),
    .frame_tick(frame_tick), .fade_in(fade_in), .fade_out(fade_out),
    .r_q(rq[0]), .g_q(gq[0]), .b_q(bq[0]), .en_q(enq[0]),
    .brightness(bri[0]), .fade_busy(busy[0])
  );

  vga_rgb_scaler #(.IN_W(2), .OUT_W(4), .BR_W(4), .STEP(5)) dut5 (
    .clk(clk), .reset(reset), .en(en), .r_d(r_d), .g_d(g_d), .b_d(b_d),
    .frame_tick(frame_tick), .fade_in(fade_in), .fade_out(fade_out),
    .r_q(rq[1]), .g_q(gq[1]), .b_q(bq[1]), .en_q(enq[1]),
    .brightness(bri[1]), .fade_busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 2-bit value spread over 4 bits: full scale 3 -> 15.
  function automatic int expand(input int d);
    return d * 15 / 3;
  endfunction

  task automatic model_reset();
    m_s1_en = 0; m_s1_r = 0; m_s1_g = 0; m_s1_b = 0; m_en_q = 0;
    for (int k = 0; k < 2; k++) begin
      m_b[k] = FULL;
      m_dir[k] = 0;
      for (int c = 0; c < 3; c++) m_q[k][c] = 0;
    end
  endtask

  task automatic model_edge();
    bit changed;
    for (int k = 0; k < 2; k++) begin
      m_q[k][0] = m_s1_en ? (expand(m_s1_r) * m_b[k]) / FULL : 0;
      m_q[k][1] = m_s1_en ? (expand(m_s1_g) * m_b[k]) / FULL : 0;
      m_q[k][2] = m_s1_en ? (expand(m_s1_b) * m_b[k]) / FULL : 0;
    end
    m_en_q  = m_s1_en;
    m_s1_en = int'(en);
    m_s1_r  = int'(r_d);
    m_s1_g  = int'(g_d);
    m_s1_b  = int'(b_d);
    for (int k = 0; k < 2; k++) begin
      changed = 1'b0;
      if (fade_out) begin
        if (m_dir[k] != -1 && !(m_dir[k] == 0 && m_b[k] == 0)) begin
          m_dir[k] = -1;
          changed = 1'b1;
        end
      end else if (fade_in) begin
        if (m_dir[k] != 1 && !(m_dir[k] == 0 && m_b[k] == FULL)) begin
          m_dir[k] = 1;
          changed = 1'b1;
        end
      end
      if (!changed && frame_tick && m_dir[k] != 0) begin
        m_b[k] = m_b[k] + m_dir[k] * step_of[k];
        if (m_b[k] >= FULL) begin
          m_b[k] = FULL;
          m_dir[k] = 0;
        end else if (m_b[k] <= 0) begin
          m_b[k] = 0;
          m_dir[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("r_q[%0d]", k), rq[k], m_q[k][0]);
      chk($sformatf("g_q[%0d]", k), gq[k], m_q[k][1]);
      chk($sformatf("b_q[%0d]", k), bq[k], m_q[k][2]);
      chk($sformatf("en_q[%0d]", k), enq[k], m_en_q);
      chk($sformatf("brightness[%0d]", k), bri[k], m_b[k]);
      chk($sformatf("fade_busy[%0d]", k), busy[k], (m_dir[k] != 0) ? 1 : 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    frame_tick = 1'b0;
    fade_in    = 1'b0;
    fade_out   = 1'b0;
    if (rnd_pix) begin
      r_d = 2'($urandom_range(3, 0));
      g_d = 2'($urandom_range(3, 0));
      b_d = 2'($urandom_range(3, 0));
    end
    if (rnd_en) en = 1'($urandom_range(1, 0));
  endtask

  task automatic tick_frame(input int gap);
    frame_tick = 1'b1;
    cyc();
    repeat (gap) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; frame_tick = 1'b0; fade_in = 1'b0; fade_out = 1'b0;
    r_d = 2'd0; g_d = 2'd0; b_d = 2'd0;
    #2;
    do_reset();

    // Passthrough at unity gain, then blanking.
    en = 1'b1; r_d = 2'd3; g_d = 2'd2; b_d = 2'd1;
    cyc();
    cyc();
    chk("pass_r", rq[0], 15);
    chk("pass_g", gq[0], 10);
    chk("pass_b", bq[0], 5);
    chk("pass_en", enq[0], 1);
    en = 1'b0; r_d = 2'd3;
    cyc();
    cyc();
    chk("blank_r", rq[0], 0);
    chk("blank_en", enq[0], 0);

    // Random pixels with en toggling.
    rnd_pix = 1'b1; rnd_en = 1'b1;
    repeat (40) cyc();

    // Full fade out: STEP=1 walks 15..0, STEP=5 clamps 11,6,1,0.
    fade_out = 1'b1;
    cyc();
    chk("fo_busy", busy[0], 1);
    repeat (16) tick_frame(2);
    chk("fo_end_b", bri[0], 0);
    chk("fo_end_busy", busy[0], 0);
    chk("fo5_end_b", bri[1], 0);

    // Request with tick in the same cycle: no step that cycle, then climb to full.
    fade_in = 1'b1; frame_tick = 1'b1;
    cyc();
    chk("fi_nostep", bri[0], 0);
    repeat (16) tick_frame(1);
    chk("fi_end_b", bri[0], 16);

    // Reversal mid-fade continues from the current level.
    fade_out = 1'b1;
    cyc();
    repeat (8) tick_frame(1);
    chk("rev_mid_b", bri[0], 8);
    fade_in = 1'b1;
    cyc();
    repeat (8) tick_frame(1);
    chk("rev_end_b", bri[0], 16);
    chk("rev_end_busy", busy[0], 0);

    // Both requests together from ON: fade_out wins.
    fade_in = 1'b1; fade_out = 1'b1;
    cyc();
    chk("coll_busy", busy[0], 1);
    repeat (20) tick_frame(0);

    // Random fade requests and ticks.
    repeat (400) begin
      fade_in    = ($urandom_range(15, 0) == 0);
      fade_out   = ($urandom_range(15, 0) == 0);
      frame_tick = ($urandom_range(3, 0) == 0);
      cyc();
    end

    // Reset mid-fade at brightness 5, asserted between clock edges.
    do_reset();
    fade_out = 1'b1;
    cyc();
    repeat (11) tick_frame(1);
    chk("mid_b", bri[0], 5);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_b", bri[0], 16);
    chk("rst_busy", busy[0], 0);
    chk("rst_r", rq[0], 0);
    #8;
    reset = 1'b0;
    repeat (10) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
